mc_control_fsm: RTL

Multi-cycle MIPS control unit: a Moore-style state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It sits directly upstream of the datapath muxes and drives their select lines: `reg_dst` feeds the 5-bit write-register mux, and `mem_to_reg`/`alu_src_a` feed the 32-bit 2:1 muxes. It also drives PC, IR, memory and register-file enables, stalls on a memory-ready handshake, and counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 74 +++++++
 rtl/mc_ctrl_decode.sv | 76 +++++++
 rtl/mc_control_fsm.sv | 107 ++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Optional feature macro: MC_CTRL_ADDI_EN (enables the addi execute/write-back states).
package mc_ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned CNT_W = 32;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_JEX,
`ifdef MC_CTRL_ADDI_EN
        S_ADDIEX,
        S_ADDIWB,
`endif
        S_ILLEGAL
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // Final states: leaving one of these for FETCH retires an instruction
    function automatic logic is_final(input state_t s);
        case (s)
            S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_JEX: return 1'b1;
`ifdef MC_CTRL_ADDI_EN
            S_ADDIWB: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> datapath control decoder (ungated; FETCH handshake applied by the top).
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Moore decode: every field defaults to 0, each state raises only its own controls
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JEX: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            S_ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, FETCH handshake gating,
// reset output forcing and retired-instruction counter.
// Optional feature macro: MC_CTRL_ADDI_EN (addi support; otherwise 001000 is illegal).
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl_out;

    mc_ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl_dec)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state logic; mem_ready only matters in the memory-access states
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:   if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_J:         state_next = S_JEX;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_next = S_ADDIEX;
`endif
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            // IR is stable after FETCH, so opcode can be re-read here
            S_MEMADR:  state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_next = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_next = S_FETCH;
            S_RTYPEEX: state_next = S_RTYPEWB;
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX:  state_next = S_ADDIWB;
            S_ADDIWB:  state_next = S_FETCH;
`endif
            S_MEMWB, S_RTYPEWB, S_BEQEX, S_JEX: state_next = S_FETCH;
            S_ILLEGAL: state_next = S_ILLEGAL;
            default:   state_next = S_FETCH;
        endcase
    end

    // Output stage: IR/PC load waits on the memory handshake in FETCH; reset silences everything
    always_comb begin
        ctrl_out = ctrl_dec;
        if (state == S_FETCH) begin
            ctrl_out.ir_write = ctrl_dec.ir_write & mem_ready;
            ctrl_out.pc_write = ctrl_dec.pc_write & mem_ready;
        end
        if (reset) ctrl_out = '0;
    end

    // Retired counter: one tick per final-state exit into FETCH, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      retired <= '0;
        else if (state_next == S_FETCH && is_final(state)) retired <= retired + CNT_W'(1);
    end

    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign reg_dst       = ctrl_out.reg_dst;
    assign reg_write     = ctrl_out.reg_write;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign pc_source     = ctrl_out.pc_source;
    assign illegal_op    = ctrl_out.illegal_op;

endmodule
